// File: rtl/cska_sched_pkg.sv
// Shared types and helpers for the carry-skip adder scheduler.
package cska_sched_pkg;

  localparam int unsigned W_DEFAULT = 16;
  localparam int unsigned BLK_W     = 4;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  // Ceiling log2, never less than 1 so index ports keep a real width.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Round-robin search starting after 'last'; returns {found, index}.
  function automatic logic [2:0] rr_next(input logic [3:0] valid,
                                         input logic [1:0] last,
                                         input int unsigned nreq);
    logic [2:0]  r;
    int unsigned t;
    r = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      t = 32'(last) + k;
      if (t >= nreq) t = t - nreq;
      if (!r[2] && (k <= nreq) && valid[t[1:0]]) r = {1'b1, t[1:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/cska_core.sv
// Combinational carry-skip adder: 4-bit ripple blocks, block-propagate skips the carry.
module cska_core
  import cska_sched_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int unsigned NBLK = (W + BLK_W - 1) / BLK_W;

  always_comb begin
    logic c_blk;
    logic c_rip;
    logic p_blk;
    logic p_bit;
    sum   = '0;
    c_blk = cin;
    c_rip = 1'b0;
    p_blk = 1'b0;
    p_bit = 1'b0;
    for (int unsigned k = 0; k < NBLK; k++) begin
      c_rip = c_blk;
      p_blk = 1'b1;
      for (int unsigned i = 0; i < BLK_W; i++) begin
        if (k * BLK_W + i < W) begin
          p_bit = a[k*BLK_W+i] ^ b[k*BLK_W+i];
          sum[k*BLK_W+i] = p_bit ^ c_rip;
          c_rip = (a[k*BLK_W+i] & b[k*BLK_W+i]) | (p_bit & c_rip);
          p_blk = p_blk & p_bit;
        end
      end
      // Whole block propagates: incoming carry bypasses the ripple chain.
      c_blk = p_blk ? c_blk : c_rip;
    end
    cout = c_blk;
  end

endmodule

// File: rtl/cska_sched.sv
// Round-robin scheduler sharing one carry-skip adder across NREQ multi-word requesters.
// Optional completed-chain counter enabled by macro CSKA_SCHED_STATS_EN.
module cska_sched
  import cska_sched_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned W    = W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*W-1:0]        req_a,
  input  logic [NREQ*W-1:0]        req_b,
  input  logic [NREQ-1:0]          req_cin,
  input  logic [NREQ-1:0]          req_last,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [W-1:0]             res_sum,
  output logic                     res_cout,
  output logic [clog2(NREQ)-1:0]   res_id,
  output logic                     res_last,
  output logic [31:0]              stat_ops
);

  localparam int unsigned IDW = clog2(NREQ);

  state_t         state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic           carry_q, carry_d;

  logic [2:0]     rr_c;
  logic [IDW-1:0] sel_c;
  logic           sel_ok_c;
  logic           out_free_c;
  logic           accept_c;
  logic [W-1:0]   a_c, b_c, sum_c;
  logic           cin_c, cout_c, last_c;

  // Pick the requester served this cycle and gate its ready on output space.
  always_comb begin
    rr_c       = rr_next(4'(req_valid), 2'(ptr_q), NREQ);
    sel_c      = owner_q;
    sel_ok_c   = 1'b0;
    req_ready  = '0;
    out_free_c = !res_valid || res_ready;
    case (state_q)
      IDLE: begin
        sel_c    = IDW'(rr_c[1:0]);
        sel_ok_c = rr_c[2];
      end
      LOCK: begin
        sel_c    = owner_q;
        sel_ok_c = 1'b1;
      end
      default: ;
    endcase
    if (sel_ok_c && out_free_c && rst_n) req_ready[sel_c] = 1'b1;
    accept_c = req_valid[sel_c] & req_ready[sel_c];
    a_c      = req_a[32'(sel_c)*W +: W];
    b_c      = req_b[32'(sel_c)*W +: W];
    last_c   = req_last[sel_c];
    cin_c    = (state_q == IDLE) ? req_cin[sel_c] : carry_q;
  end

  cska_core #(.W(W)) u_core (
    .a    (a_c),
    .b    (b_c),
    .cin  (cin_c),
    .sum  (sum_c),
    .cout (cout_c)
  );

  // Next-state: lock on a non-final word, release and advance pointer on the final one.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    carry_d = carry_q;
    if (accept_c) begin
      owner_d = sel_c;
      if (last_c) begin
        state_d = IDLE;
        ptr_d   = sel_c;
        carry_d = 1'b0;
      end else begin
        state_d = LOCK;
        carry_d = cout_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      carry_q <= carry_d;
    end
  end

  // Result register: loads on accept, holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_cout  <= 1'b0;
      res_id    <= '0;
      res_last  <= 1'b0;
    end else if (accept_c) begin
      res_valid <= 1'b1;
      res_sum   <= sum_c;
      res_cout  <= cout_c;
      res_id    <= sel_c;
      res_last  <= last_c;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

`ifdef CSKA_SCHED_STATS_EN
  logic [31:0] ops_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_q <= '0;
    end else if (res_valid && res_ready && res_last) begin
      ops_q <= ops_q + 32'd1;
    end
  end

  assign stat_ops = ops_q;
`else
  assign stat_ops = '0;
`endif

endmodule

// File: tb/tb_cska_sched.sv
// Directed scoreboard bench for cska_sched (NREQ=2, W=16).
module tb_cska_sched;

  localparam int unsigned NREQ = 2;
  localparam int unsigned W    = 16;
  localparam int unsigned WP1  = W + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_cin;
  logic [NREQ-1:0]   req_last;
  logic              res_valid;
  logic              res_ready;
  logic [W-1:0]      res_sum;
  logic              res_cout;
  logic [0:0]        res_id;
  logic              res_last;
  logic [31:0]       stat_ops;

  always #5 clk = ~clk;

  cska_sched #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_last  (req_last),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_cout  (res_cout),
    .res_id    (res_id),
    .res_last  (res_last),
    .stat_ops  (stat_ops)
  );

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic [0:0]   id;
    logic         last;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        m_first = 1'b1;
  logic        m_carry = 1'b0;
  int unsigned m_stat = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic clr();
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    req_last  = '0;
  endtask

  task automatic put_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic last);
    req_valid[i]      = 1'b1;
    req_a[i*W +: W]   = a;
    req_b[i*W +: W]   = b;
    req_cin[i]        = cin;
    req_last[i]       = last;
  endtask

  // One clock: retire/compare output, predict accepted word, advance to posedge+1.
  task automatic tick();
    exp_t         e;
    logic [W:0]   r;
    logic         ci;
    @(negedge clk);
    chk("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
    if (res_valid && res_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $error("FAIL unexpected_result: observed sum 0x%0h, expected no result", res_sum);
      end else begin
        e = sb.pop_front();
        chk("res_sum", 32'(res_sum), 32'(e.sum));
        chk("res_id", 32'(res_id), 32'(e.id));
        chk("res_last", 32'(res_last), 32'(e.last));
        if (e.last) begin
          chk("res_cout", 32'(res_cout), 32'(e.cout));
          m_stat++;
        end
      end
    end
    for (int i = 0; i < int'(NREQ); i++) begin
      if (req_valid[i] && req_ready[i]) begin
        ci = m_first ? req_cin[i] : m_carry;
        r  = WP1'(req_a[i*W +: W]) + WP1'(req_b[i*W +: W]) + WP1'(ci);
        sb.push_back('{sum: r[W-1:0], cout: r[W], id: 1'(i), last: req_last[i]});
        m_carry = r[W];
        m_first = req_last[i];
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0]  eg;
    logic [31:0] stat_exp;

    // Reset with requests pending: no ready, all outputs cleared.
    rst_n     = 1'b0;
    res_ready = 1'b1;
    clr();
    req_valid = 2'b11;
    #2;
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_res_sum", 32'(res_sum), 32'd0);
    chk("rst_stat_ops", stat_ops, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    clr();
    rst_n = 1'b1;

    // Single word from req0.
    put_req(0, 16'h00FF, 16'h0001, 1'b0, 1'b1);
    #1;
    chk("single_ready", 32'(req_ready), 32'd1);
    tick();
    clr();
    chk("single_valid", 32'(res_valid), 32'd1);
    chk("single_sum", 32'(res_sum), 32'h0100);
    chk("single_cout", 32'(res_cout), 32'd0);
    chk("single_id", 32'(res_id), 32'd0);
    chk("single_last", 32'(res_last), 32'd1);
    tick();

    // Contention, pointer at 0: grants alternate 1,0,1,0.
    for (int k = 0; k < 4; k++) begin
      put_req(0, 16'(k), 16'h0010, 1'b0, 1'b1);
      put_req(1, 16'(k * 2), 16'h0100, 1'b1, 1'b1);
      #1;
      eg = k[0] ? 2'b01 : 2'b10;
      chk("contend_grant", 32'(req_ready), 32'(eg));
      tick();
    end
    clr();
    tick();

    // Two-word chain on req1 with req0 waiting; owner drops valid for one cycle.
    put_req(0, 16'h1234, 16'h1111, 1'b0, 1'b1);
    put_req(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    #1;
    chk("chain_w0_ready", 32'(req_ready), 32'd2);
    tick();
    chk("chain_sum0", 32'(res_sum), 32'h0000);
    req_valid[1] = 1'b0;
    #1;
    chk("chain_stall_ready", 32'(req_ready), 32'd2);
    tick();
    put_req(1, 16'h0000, 16'h0000, 1'b1, 1'b1);
    #1;
    chk("chain_w1_ready", 32'(req_ready), 32'd2);
    tick();
    chk("chain_sum1", 32'(res_sum), 32'h0001);
    chk("chain_cout1", 32'(res_cout), 32'd0);
    clr();
    tick();

    // Carry through every skip block.
    put_req(0, 16'hAAAA, 16'h5555, 1'b1, 1'b1);
    #1;
    chk("skip_ready", 32'(req_ready), 32'd1);
    tick();
    clr();
    chk("skip_sum", 32'(res_sum), 32'h0000);
    chk("skip_cout", 32'(res_cout), 32'd1);
    tick();

    // Backpressure: output holds, no accept, then resume without loss.
    put_req(0, 16'h0003, 16'h0004, 1'b0, 1'b1);
    #1;
    chk("bp_first_ready", 32'(req_ready), 32'd1);
    tick();
    res_ready = 1'b0;
    put_req(0, 16'h0010, 16'h0020, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_valid", 32'(res_valid), 32'd1);
      chk("bp_hold_sum", 32'(res_sum), 32'h0007);
      chk("bp_hold_last", 32'(res_last), 32'd1);
      tick();
    end
    res_ready = 1'b1;
    #1;
    chk("bp_resume_ready", 32'(req_ready), 32'd1);
    tick();
    clr();
    chk("bp_second_sum", 32'(res_sum), 32'h0030);
    tick();
    chk("bp_drained", 32'(sb.size()), 32'd0);

    // Reset in the middle of a chain, then a fresh chain must use req_cin.
    put_req(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    #1;
    chk("lock_ready", 32'(req_ready), 32'd1);
    tick();
    clr();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_sum", 32'(res_sum), 32'd0);
    chk("mid_rst_cout", 32'(res_cout), 32'd0);
    chk("mid_rst_id", 32'(res_id), 32'd0);
    chk("mid_rst_last", 32'(res_last), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_stat", stat_ops, 32'd0);
    sb.delete();
    m_first = 1'b1;
    m_carry = 1'b0;
    m_stat  = 0;
    tick();
    rst_n = 1'b1;
    put_req(0, 16'h0001, 16'h0001, 1'b0, 1'b1);
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    tick();
    clr();
    chk("post_rst_sum", 32'(res_sum), 32'h0002);
    tick();
    tick();

    chk("final_drained", 32'(sb.size()), 32'd0);
`ifdef CSKA_SCHED_STATS_EN
    stat_exp = m_stat;
`else
    stat_exp = 32'd0;
`endif
    chk("stat_ops", stat_ops, stat_exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
